// File: rtl/fix2flt_engine_if.sv
// Start/done handshake between the host and the fix2flt_engine converter.
interface fix2flt_engine_if;
  logic        start;
  logic [15:0] data_in;
  logic        busy;
  logic        done;
  logic [15:0] flt_out;

  modport master (output start, output data_in, input busy, input done, input flt_out);
  modport slave  (input start, input data_in, output busy, output done, output flt_out);
endinterface

// File: rtl/fix2flt_engine.sv
// Sequential 16-bit two's-complement to binary16 converter with round-to-nearest-even.
// FIX2FLT_FAST_NORM_EN selects single-cycle normalization (priority encoder + barrel shift).
//
// state | meaning
// IDLE  | waiting for start
// NORM  | left-normalizing the magnitude
// ROUND | rounding and assembling flt_out
// DONE  | result valid, waiting for next start
module fix2flt_engine #(
  parameter int BIAS = 15
) (
  input  logic             clk,
  input  logic             reset,
  fix2flt_engine_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state, state_nx;
  logic        sign;
  logic [15:0] mag;
  logic [4:0]  exp;
  logic [15:0] flt_q;

  logic        accept;
  logic        norm_end;
  logic [15:0] mag_in;
  logic        round_up;
  logic [10:0] m_sum;
  logic [4:0]  exp_r;

`ifdef FIX2FLT_FAST_NORM_EN
  logic [3:0]  lz;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    lz = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (mag[i]) lz = 4'(15 - i);
    end
  end

  assign norm_end = 1'b1;
`else
  assign norm_end = mag[15] || (mag == 16'h0000);
`endif

  assign accept = ((state == IDLE) || (state == DONE)) && bus.start;
  assign mag_in = bus.data_in[15] ? (~bus.data_in + 16'd1) : bus.data_in;

  assign round_up = mag[4] && ((|mag[3:0]) || mag[5]);
  assign m_sum    = {1'b0, mag[14:5]} + {10'd0, round_up};
  assign exp_r    = m_sum[10] ? (exp + 5'd1) : exp;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = NORM;
      NORM:    if (norm_end) state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    if (bus.start) state_nx = NORM;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign  <= 1'b0;
      mag   <= 16'h0000;
      exp   <= 5'd0;
      flt_q <= 16'h0000;
    end else if (accept) begin
      sign <= bus.data_in[15];
      mag  <= mag_in;
      exp  <= 5'(BIAS + 15);
    end else if (state == NORM) begin
`ifdef FIX2FLT_FAST_NORM_EN
      mag <= mag << lz;
      exp <= exp - {1'b0, lz};
`else
      if (!norm_end) begin
        mag <= mag << 1;
        exp <= exp - 5'd1;
      end
`endif
    end else if (state == ROUND) begin
      if (mag == 16'h0000) flt_q <= 16'h0000;
      else                 flt_q <= {sign, exp_r, m_sum[9:0]};
    end
  end

  assign bus.busy    = (state == NORM) || (state == ROUND);
  assign bus.done    = (state == DONE);
  assign bus.flt_out = flt_q;

endmodule

// File: tb/tb_fix2flt_engine.sv
// Directed self-checking bench for fix2flt_engine; latencies follow FIX2FLT_FAST_NORM_EN when defined.
module tb_fix2flt_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] last_flt = 16'h0000;

  fix2flt_engine_if bus ();

  fix2flt_engine #(.BIAS(15)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic int lat(input int serial_lat);
`ifdef FIX2FLT_FAST_NORM_EN
    return 2;
`else
    return serial_lat;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Starts a conversion at the next edge, then watches busy/done until completion.
  task automatic run(input string tag, input logic [15:0] d, input logic [15:0] expf,
                     input int explat, input int pulse_k, input bit scramble);
    int k;
    @(negedge clk);
    bus.start = 1'b1;
    bus.data_in = d;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    chk({tag, "_done_cleared"}, 32'(bus.done), 32'd0);
    chk({tag, "_flt_held"}, 32'(bus.flt_out), 32'(last_flt));
    while (!bus.done && k < 40) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (scramble) bus.data_in = 16'($urandom_range(0, 65535));
      if (k == pulse_k) begin
        bus.start = 1'b1;
        bus.data_in = 16'h7FFF;
      end
      @(negedge clk);
      bus.start = 1'b0;
      k++;
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_latency"}, 32'(k), 32'(explat));
    chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    chk({tag, "_flt_out"}, 32'(bus.flt_out), 32'(expf));
    last_flt = expf;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.data_in = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_flt", 32'(bus.flt_out), 32'h0);
    reset = 1'b0;

    run("one",     16'h0001, 16'h3C00, lat(17), -1, 1'b0);
    run("neg_two", 16'hFFFE, 16'hC000, lat(16), -1, 1'b0);
    run("min_neg", 16'h8000, 16'hF800, 2,       -1, 1'b0);
    run("max_pos", 16'h7FFF, 16'h7800, lat(3),  -1, 1'b0);
    run("tie_dn",  16'h0801, 16'h6800, lat(6),  -1, 1'b0);
    run("tie_up",  16'h0803, 16'h6802, lat(6),  -1, 1'b0);
    run("zero",    16'h0000, 16'h0000, 2,       -1, 1'b0);
    run("scram",   16'h0803, 16'h6802, lat(6),  -1, 1'b1);

    // Back-to-back: restart straight from DONE, with a stray start pulse mid-NORM.
    run("b2b_a",   16'h0001, 16'h3C00, lat(17), -1, 1'b0);
    run("b2b_b",   16'h0005, 16'h4500, lat(15),  3, 1'b0);

    // Reset in the middle of normalizing 0x0001.
    @(negedge clk);
    bus.start = 1'b1;
    bus.data_in = 16'h0001;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_flt", 32'(bus.flt_out), 32'h0);
    last_flt = 16'h0000;
    run("after_rst", 16'h0003, 16'h4200, lat(16), -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fix2flt_engine.md
# fix2flt_engine

Sequential converter from 16-bit two's-complement integer to 16-bit binary16-style float (1 sign, 5 exponent, 10 mantissa bits, round-to-nearest-even). It is the reverse-direction companion of the flt2fix datapath. It sits beside the 9-bit-ISA core as a start/done accelerator: the host loads `data_in`, pulses `start`, and reads `flt_out` once `done` is high.

## Interface
- `BIAS`, default 15: exponent bias. Legal range is 1..15; other values are unsupported.
- `clk`  in  1  clock, rising-edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `data_in`  in  16  two's-complement operand; captured on the accepting edge only.
- `busy`  out  1  high in NORM and ROUND.
- `done`  out  1  high in DONE; held until the next accepted start or reset.
- `flt_out`  out  16  `{sign, exp[4:0], mant[9:0]}`; valid while `done` is high.

## Operation
- States and transitions:
  - IDLE: if `start`, accept the operand and go to NORM.
  - NORM: go to ROUND when `mag[15]==1` or `mag==0`.
  - ROUND: go to DONE.
  - DONE: if `start`, accept a new operand and go to NORM; otherwise stay in DONE.
- Capture, on the accepting edge:
  - `sign <= data_in[15]`.
  - `mag <= sign ? -data_in : data_in`, as 16-bit unsigned. 0x8000 gives `mag` 0x8000.
  - `exp <= BIAS+15`, held in a 5-bit register.
- NORM: each cycle, if `mag[15]==0 && mag!=0`, then `mag <= mag<<1` and `exp <= exp-1`. This is one bit per cycle, at most 15 shifts.
- ROUND, rounding bits:
  - `m = mag[14:5]`, `G = mag[4]`, `S = |mag[3:0]`.
  - Round up when `G && (S || m[0])`.
- ROUND, output assembly:
  - If the round-up carries out of `m`, then `m=0` and `exp+1`.
  - `flt_out <= {sign, exp, m}`.
  - If `mag==0`, `flt_out <= 16'h0000`. Zero is always positive.
- With `BIAS<=15` the exponent never exceeds 30. No infinity or NaN is produced; no subnormals are needed.
- `start` in NORM or ROUND is ignored. `data_in` changes outside the accepting edge have no effect.

## Timing
- Reset values:
  - State IDLE.
  - `busy=0`, `done=0`, `flt_out=16'h0000`.
  - `mag`, `sign`, `exp` all 0.
- Reset mid-conversion aborts the conversion and returns to IDLE next edge; no partial result is driven.
- Latency: let edge 0 be the accepting edge and `n` the leading-zero count of `mag` (0..15; 0 for `mag==0`).
  - `done` and `flt_out` are valid after edge n+2.
  - Worst case is 17 cycles (input 1 or -1).
- `busy` is high from edge 0 through edge n+1. `busy` and `done` are never both high.
- Accepting `start` in DONE clears `done` on the same edge (back-to-back conversions). `flt_out` holds its old value until the next ROUND→DONE edge.
- A held `start` in DONE restarts every completion. The host must deassert `start` after acceptance.

## Configuration
- `FIX2FLT_FAST_NORM_EN`
  - Defined: NORM completes in exactly one cycle using a priority encoder plus barrel shift (`mag <<= lz`, `exp -= lz`). Latency is a fixed 2 cycles (done after edge 2) for every input. Results are bit-identical to the serial version.
  - Undefined: one-bit-per-cycle serial normalization as described above. This is the default.

## Test plan
Latencies are for the default build. Rows 5 and 6 also run with `FIX2FLT_FAST_NORM_EN`, where every latency is 2.
- `data_in=0x0001`, start one cycle -> `flt_out=0x3C00`, done after edge 17; `busy` high for 17 cycles beforehand.
- `data_in=0xFFFE` (-2) -> `0xC000`. `data_in=0x8000` (-32768) -> `0xF800`, latency 2.
- Rounding (all inputs below):
  - `0x7FFF` -> `0x7800` (round-up with mantissa carry into exponent).
  - `0x0801` (2049) -> `0x6800` (tie to even, down).
  - `0x0803` (2051) -> `0x6802` (tie to even, up).
- `data_in=0x0000` -> `flt_out=0x0000`, done after edge 2. `data_in` toggled while busy -> result unchanged.
- Back-to-back operands (`0x0001`, then `0x0005`):
  - Start `0x0001`; at completion start again with `0x0005` -> `done` drops same edge, then `flt_out=0x4500`.
  - `start` pulsed mid-NORM -> ignored.
- Reset asserted during NORM of `0x0001` -> next cycle IDLE, `done=0`, `busy=0`, `flt_out=0x0000`. Subsequent conversion of `0x0003` -> `0x4200`.
